// File: rtl/ht_bm_pkg.sv
// ht_bm_pkg: shared types and helpers for the hashtable match-bitmap writer.
//   bm_op_t  : command opcode (BM_CLR=0, BM_SET=1)
//   wr_fsm_t : writer control states (IDLE, DRAIN, SWEEP)
//   bm_merge : applies a set/clear of one bit to a bitmap byte
package ht_bm_pkg;

    localparam int BM_WORD_W = 8;

    typedef enum logic {
        BM_CLR = 1'b0,
        BM_SET = 1'b1
    } bm_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWEEP = 2'd2
    } wr_fsm_t;

    function automatic logic [BM_WORD_W-1:0] bm_merge(
        input logic [BM_WORD_W-1:0] data,
        input logic [2:0]           bit_idx,
        input bm_op_t               op
    );
        logic [BM_WORD_W-1:0] mask;
        mask = BM_WORD_W'(1) << bit_idx;
        return (op == BM_SET) ? (data | mask) : (data & ~mask);
    endfunction

endpackage

// File: rtl/ht_bm_inflight.sv
// ht_bm_inflight: DEPTH-deep shift register tracking accepted read-modify-write
// ops from acceptance until their write cycle.
//   Stage k holds the op accepted k+1 cycles ago. Stage DEPTH-2 is the op whose
//   read data is arriving this cycle (merge stage); stage DEPTH-1 is the op
//   being written this cycle.
// Ports:
//   clk, rst                  clock, async active-high reset
//   push, push_addr/bit/op    op accepted this cycle
//   probe_addr, hit           byte address compare against every valid stage
//   any_valid                 some stage holds an op
//   head_valid/addr/bit/op    merge-stage entry
module ht_bm_inflight
    import ht_bm_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [2:0]    push_bit,
    input  bm_op_t        push_op,
    input  logic [AW-1:0] probe_addr,
    output logic          hit,
    output logic          any_valid,
    output logic          head_valid,
    output logic [AW-1:0] head_addr,
    output logic [2:0]    head_bit,
    output bm_op_t        head_op
);

    localparam int HEAD = DEPTH - 2;

    logic [DEPTH-1:0]         vld;
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][2:0]    bit_q;
    logic [DEPTH-1:0]         op_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld    <= '0;
            addr_q <= '0;
            bit_q  <= '0;
            op_q   <= '0;
        end else begin
            vld    <= {vld[DEPTH-2:0], push};
            addr_q <= {addr_q[DEPTH-2:0], push_addr};
            bit_q  <= {bit_q[DEPTH-2:0], push_bit};
            op_q   <= {op_q[DEPTH-2:0], logic'(push_op)};
        end
    end

    // Includes the write stage: a read issued in the write cycle would see
    // stale RAM data, so that byte must still block.
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            if (vld[k] && (addr_q[k] == probe_addr)) hit = 1'b1;
    end

    assign any_valid  = |vld;
    assign head_valid = vld[HEAD];
    assign head_addr  = addr_q[HEAD];
    assign head_bit   = bit_q[HEAD];
    assign head_op    = bm_op_t'(op_q[HEAD]);

endmodule

// File: rtl/hashtable_bm_writer.sv
// hashtable_bm_writer: runtime programmer for the Pigasus hashtable match bitmap.
// Set/clear commands on NBITS-wide hash addresses are applied as read-modify-write
// of byte addr[NBITS-1:3], bit addr[2:0]. A clear-all request drains in-flight ops
// and then zeroes every byte, one per cycle.
// Ports:
//   clk, rst                         clock, async active-high reset
//   cmd_valid/ready/addr/op          command handshake (op 1=set, 0=clear)
//   clr_all_req                      pulse: zero the whole bitmap
//   busy, clr_done                   activity flag, sweep-complete pulse
//   ram_rd_en/addr, ram_rd_data      bitmap read port (data RD_LAT cycles later)
//   ram_wr_en/addr/data              bitmap write port
// Optional (macro HT_BM_STATS_EN): stat_rst input, stat_set_cnt/stat_clr_cnt
// saturating counters of accepted set/clear commands.
// RD_LAT legal range 1..4; BM_AWIDTH must equal NBITS-3.
module hashtable_bm_writer
    import ht_bm_pkg::*;
#(
    parameter int NBITS     = 15,
    parameter int BM_AWIDTH = 12,
    parameter int RD_LAT    = 2
) (
`ifdef HT_BM_STATS_EN
    input  logic                 stat_rst,
    output logic [31:0]          stat_set_cnt,
    output logic [31:0]          stat_clr_cnt,
`endif
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [NBITS-1:0]     cmd_addr,
    input  logic                 cmd_op,
    input  logic                 clr_all_req,
    output logic                 busy,
    output logic                 clr_done,
    output logic                 ram_rd_en,
    output logic [BM_AWIDTH-1:0] ram_rd_addr,
    input  logic [BM_WORD_W-1:0] ram_rd_data,
    output logic                 ram_wr_en,
    output logic [BM_AWIDTH-1:0] ram_wr_addr,
    output logic [BM_WORD_W-1:0] ram_wr_data
);

    wr_fsm_t                state;
    logic [BM_AWIDTH-1:0]   sweep_cnt;
    logic                   wr_en_q;
    logic [BM_AWIDTH-1:0]   wr_addr_q;
    logic [BM_WORD_W-1:0]   wr_data_q;

    logic [BM_AWIDTH-1:0]   byte_addr;
    logic [2:0]             bit_idx;
    logic                   hit;
    logic                   any_valid;
    logic                   accept;
    logic                   head_valid;
    logic [BM_AWIDTH-1:0]   head_addr;
    logic [2:0]             head_bit;
    bm_op_t                 head_op;

    assign byte_addr = cmd_addr[NBITS-1:3];
    assign bit_idx   = cmd_addr[2:0];

    // A clear request in the same cycle takes priority over the command.
    assign cmd_ready = (state == IDLE) && !clr_all_req && !hit;
    assign accept    = cmd_valid && cmd_ready;

    assign ram_rd_en   = accept;
    assign ram_rd_addr = accept ? byte_addr : '0;

    ht_bm_inflight #(
        .DEPTH (RD_LAT + 1),
        .AW    (BM_AWIDTH)
    ) u_inflight (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .push_addr  (byte_addr),
        .push_bit   (bit_idx),
        .push_op    (bm_op_t'(cmd_op)),
        .probe_addr (byte_addr),
        .hit        (hit),
        .any_valid  (any_valid),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_bit   (head_bit),
        .head_op    (head_op)
    );

    // Merge stage: read data for the head op arrives now; write next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= head_valid;
            if (head_valid) begin
                wr_addr_q <= head_addr;
                wr_data_q <= bm_merge(ram_rd_data, head_bit, head_op);
            end
        end
    end

    // Control FSM. The sweep counter wraps to 0 after the last byte, which is
    // also the cycle the completion pulse is raised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sweep_cnt <= '0;
            clr_done  <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_all_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (!any_valid) begin
                        state     <= SWEEP;
                        sweep_cnt <= '0;
                    end
                end
                SWEEP: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (&sweep_cnt) begin
                        state    <= IDLE;
                        clr_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The pipeline is empty during SWEEP, so the two write sources never overlap.
    assign ram_wr_en   = (state == SWEEP) || wr_en_q;
    assign ram_wr_addr = (state == SWEEP) ? sweep_cnt : wr_addr_q;
    assign ram_wr_data = (state == SWEEP) ? '0 : wr_data_q;

    assign busy = (state != IDLE) || any_valid;

`ifdef HT_BM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_set_cnt <= '0;
            stat_clr_cnt <= '0;
        end else if (stat_rst) begin
            stat_set_cnt <= '0;
            stat_clr_cnt <= '0;
        end else if (accept) begin
            if (cmd_op && !(&stat_set_cnt))  stat_set_cnt <= stat_set_cnt + 32'd1;
            if (!cmd_op && !(&stat_clr_cnt)) stat_clr_cnt <= stat_clr_cnt + 32'd1;
        end
    end
`endif

endmodule
